pe_mac_int: RTL and testbench
=============================

// Module: pe_mac_int
// PURPOSE
//  Parametrised integer multiply-accumulate processing element for the systolic matrix multiplier.
//  Successor to the single-lane FP PE: packs LANES operands per word, runs a 2-stage pipelined MAC,
//  clears the accumulator per dot product, optionally saturates, and drains on request.
//  Forwards row/column operands to east/south neighbours one cycle after acceptance.
// PARAMETERS
//  DATA_W   8   operand width per lane (8/16/32 = int8/int16/int32 modes)
//  LANES    1   SIMD lanes packed in row_in/col_in; lane k = bits [k*DATA_W +: DATA_W]
//  ACC_W    32  accumulator width; must be >= 2*DATA_W + clog2(LANES)
//  SIGNED   1   1 = two's-complement operands, 0 = unsigned
//  SAT      0   1 = saturate accumulator at ACC_W limits, 0 = wrap modulo 2^ACC_W
// PORTS
//  clk         in   1               clock, all logic on rising edge
//  rst         in   1               synchronous, active-high reset
//  load_in     in   1               operand pair valid this cycle
//  acc_clr     in   1               qualifies load_in: this product starts a new dot product
//  row_in      in   DATA_W*LANES    packed row operands
//  col_in      in   DATA_W*LANES    packed column operands
//  drain_in    in   1               request: present accumulated result
//  ready_out   out  1               1 = load_in accepted this cycle
//  load_out    out  1               registered accepted load, to neighbour load_in
//  row_out     out  DATA_W*LANES    registered row_in of last accepted load
//  col_out     out  DATA_W*LANES    registered col_in of last accepted load
//  pe_result   out  ACC_W           result captured at drain; held until next drain
//  result_vld  out  1               one-cycle pulse, pe_result updated this cycle
//  overflow    out  1               sticky: accumulation overflowed since last clear
//  done_pe     out  1               1 = pipeline empty and no drain pending
// BEHAVIOUR
//  Reset: all outputs 0 except ready_out=1, done_pe=1; acc=0, state IDLE, pipeline valids 0.
//  rst mid-operation aborts everything; in-flight products and pending drains discarded.
//  FSM: IDLE -> RUN on accepted load; RUN/IDLE -> FLUSH on drain_in; FLUSH -> OUT when both
//   stage valids 0; OUT -> IDLE (acc retained). ready_out = (state==IDLE||state==RUN).
//  Accept = load_in & ready_out. Loads while not ready are dropped: no forward, no MAC.
//  Forward: on accept, row_out/col_out <= row_in/col_in, load_out <= 1 next cycle; else load_out <= 0,
//   row_out/col_out hold.
//  Stage 1 (edge after accept): p_reg <= sum over lanes of row_k*col_k, each product 2*DATA_W,
//   sign- (SIGNED=1) or zero-extended to ACC_W before summing; p_vld<=1, p_clr<=acc_clr.
//  Stage 2 (edge after p_vld): acc <= p_clr ? p_reg : acc + p_reg. Latency: accept at edge N ->
//   acc updated at edge N+2. Back-to-back accepts each cycle give full throughput.
//  Overflow: signed/unsigned overflow of acc+p_reg sets overflow; SAT=1 clamps to max/min
//   representable, SAT=0 wraps. p_clr product clears overflow then re-evaluates nothing (no add).
//  drain_in and accepted load in same cycle: load is accepted and included in the result.
//  drain_in in FLUSH/OUT ignored. In OUT: pe_result <= acc, result_vld=1 for that cycle only.
//  drain_in in IDLE with empty pipeline: result after 2 cycles (FLUSH 1, OUT 1).
//  done_pe = ~p_vld & ~s1_vld & state!=FLUSH & state!=OUT.
// TESTING
//  DATA_W=8,LANES=1: load(3,-4,clr=1), load(5,6), drain -> pe_result=18, result_vld 1 pulse, overflow=0.
//  LANES=4, row=[1,2,3,4], col=[5,6,7,8] clr=1, drain -> pe_result=70; row_out/col_out echo inputs next cycle.
//  SIGNED=0,SAT=1,ACC_W=16: 2 loads 255*255 (clr on first) -> pe_result=16'hFFFF, overflow=1; next clr load clears it.
//  SAT=0 same stimulus -> pe_result=(130050 mod 65536)=64514, overflow=1.
//  drain_in with load_in same cycle, 3 loads of 2*2 -> pe_result=12; load_in during FLUSH dropped, load_out=0.
//  rst asserted one cycle after a load -> next cycle all outputs at reset values, no result_vld.

Source files
------------

// File: rtl/pe_mac_int_if.sv
// rtl/pe_mac_int_if.sv - operand, forward and result bundle of the integer MAC processing element
interface pe_mac_int_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1,
    parameter int ACC_W  = 32
);
    logic                      load_in;
    logic                      acc_clr;
    logic [DATA_W*LANES-1:0]   row_in;
    logic [DATA_W*LANES-1:0]   col_in;
    logic                      drain_in;
    logic                      ready_out;
    logic                      load_out;
    logic [DATA_W*LANES-1:0]   row_out;
    logic [DATA_W*LANES-1:0]   col_out;
    logic [ACC_W-1:0]          pe_result;
    logic                      result_vld;
    logic                      overflow;
    logic                      done_pe;

    modport master (
        output load_in, acc_clr, row_in, col_in, drain_in,
        input  ready_out, load_out, row_out, col_out, pe_result, result_vld, overflow, done_pe
    );

    modport slave (
        input  load_in, acc_clr, row_in, col_in, drain_in,
        output ready_out, load_out, row_out, col_out, pe_result, result_vld, overflow, done_pe
    );
endinterface

// File: rtl/pe_mac_int.sv
// rtl/pe_mac_int.sv - SIMD integer multiply-accumulate processing element with operand forwarding
module pe_mac_int #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1,
    parameter int SAT    = 0
) (
    input  logic        clk,
    input  logic        rst,
    pe_mac_int_if.slave bus
);
    localparam int VW = DATA_W * LANES;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

    state_t             state_q, state_d;
    logic               ready;
    logic               accept;
    // Input capture stage; the captured operands double as the east/south forward.
    logic               s1_vld_q, s1_vld_d;
    logic               s1_clr_q, s1_clr_d;
    logic [VW-1:0]      row_q, row_d;
    logic [VW-1:0]      col_q, col_d;
    // Product stage
    logic               p_vld_q, p_vld_d;
    logic               p_clr_q, p_clr_d;
    logic [ACC_W-1:0]   p_reg_q, p_reg_d;
    // Accumulator and result
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_vld_q, res_vld_d;
    logic [ACC_W-1:0]   dot;
    logic [ACC_W:0]     sum;
    logic               add_ovf;
    logic [ACC_W-1:0]   sat_val;

    // Widen one lane operand to accumulator width; the low ACC_W bits of the
    // widened product equal the extended 2*DATA_W product because ACC_W >= 2*DATA_W.
    function automatic logic [ACC_W-1:0] widen(input logic [DATA_W-1:0] v);
        logic [ACC_W-1:0] r;
        r = {ACC_W{(SIGNED != 0) && v[DATA_W-1]}};
        r[DATA_W-1:0] = v;
        return r;
    endfunction

    assign ready  = (state_q == IDLE) || (state_q == RUN);
    assign accept = bus.load_in & ready;

    assign bus.ready_out  = ready;
    assign bus.load_out   = s1_vld_q;
    assign bus.row_out    = row_q;
    assign bus.col_out    = col_q;
    assign bus.pe_result  = res_q;
    assign bus.result_vld = res_vld_q;
    assign bus.overflow   = ovf_q;
    assign bus.done_pe    = ~p_vld_q & ~s1_vld_q & (state_q != FLUSH) & (state_q != OUT);

    // Next state: drains wait for both pipeline stages to empty before presenting
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.drain_in) state_d = FLUSH;
                     else if (accept)  state_d = RUN;
            RUN:     if (bus.drain_in) state_d = FLUSH;
            FLUSH:   if (!s1_vld_q && !p_vld_q) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane dot product of the captured operands
    always_comb begin
        dot = '0;
        for (int k = 0; k < LANES; k++) begin
            dot = dot + widen(row_q[k*DATA_W +: DATA_W]) * widen(col_q[k*DATA_W +: DATA_W]);
        end
    end

    // Accumulate with overflow detection, then the pipeline/forward/result next values
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, p_reg_q};
        add_ovf = (SIGNED != 0)
                ? ((acc_q[ACC_W-1] == p_reg_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                : sum[ACC_W];
        // Signed overflow can only happen toward the sign of the operands.
        sat_val = (SIGNED != 0)
                ? (acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                : {ACC_W{1'b1}};

        row_d    = accept ? bus.row_in : row_q;
        col_d    = accept ? bus.col_in : col_q;
        s1_vld_d = accept;
        s1_clr_d = accept & bus.acc_clr;
        p_vld_d  = s1_vld_q;
        p_clr_d  = s1_clr_q;
        p_reg_d  = s1_vld_q ? dot : p_reg_q;

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (p_vld_q) begin
            if (p_clr_q) begin
                acc_d = p_reg_q;
                ovf_d = 1'b0;
            end else if (add_ovf) begin
                acc_d = (SAT != 0) ? sat_val : sum[ACC_W-1:0];
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        res_d     = res_q;
        res_vld_d = 1'b0;
        if (state_q == FLUSH && state_d == OUT) begin
            res_d     = acc_q;
            res_vld_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Pipeline, forward, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_clr_q  <= 1'b0;
            p_vld_q   <= 1'b0;
            p_clr_q   <= 1'b0;
            p_reg_q   <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            s1_vld_q  <= s1_vld_d;
            s1_clr_q  <= s1_clr_d;
            p_vld_q   <= p_vld_d;
            p_clr_q   <= p_clr_d;
            p_reg_q   <= p_reg_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end
endmodule

// File: tb/tb_pe_mac_int.sv
// tb/tb_pe_mac_int.sv - self-checking bench for pe_mac_int with a behavioural MAC model
module tb_pe_mac_int;
    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -AMAX - 1;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     failures = 0;
    longint a_acc = 0;
    bit     a_ovf = 1'b0;
    int     b_sat = 0;
    int     c_wrap = 0;
    bit     b_ovf = 1'b0;
    bit     c_ovf = 1'b0;

    always #5 clk = ~clk;

    pe_mac_int_if #(.DATA_W(8), .LANES(4), .ACC_W(32)) ia ();
    pe_mac_int_if #(.DATA_W(8), .LANES(1), .ACC_W(16)) ib ();
    pe_mac_int_if #(.DATA_W(8), .LANES(1), .ACC_W(16)) ic ();

    assign ic.load_in  = ib.load_in;
    assign ic.acc_clr  = ib.acc_clr;
    assign ic.row_in   = ib.row_in;
    assign ic.col_in   = ib.col_in;
    assign ic.drain_in = ib.drain_in;

    pe_mac_int #(.DATA_W(8), .LANES(4), .ACC_W(32), .SIGNED(1), .SAT(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
    pe_mac_int #(.DATA_W(8), .LANES(1), .ACC_W(16), .SIGNED(0), .SAT(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
    pe_mac_int #(.DATA_W(8), .LANES(1), .ACC_W(16), .SIGNED(0), .SAT(0)) u_c (.clk(clk), .rst(rst), .bus(ic));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Signed 4-lane int8 dot product, 32-bit wrapping accumulator
    task automatic a_model(input logic [31:0] row, input logic [31:0] col, input bit clr);
        longint     p;
        logic [7:0] r8, c8;
        p = 0;
        for (int k = 0; k < 4; k++) begin
            r8 = row[k*8 +: 8];
            c8 = col[k*8 +: 8];
            p += longint'($signed(r8)) * longint'($signed(c8));
        end
        if (clr) begin
            a_acc = p;
            a_ovf = 1'b0;
        end else begin
            a_acc += p;
            if (a_acc > AMAX || a_acc < AMIN) begin
                a_ovf = 1'b1;
                a_acc = longint'($signed(a_acc[31:0]));
            end
        end
    endtask

    // Unsigned uint8 product into 16-bit accumulators: saturating (b) and wrapping (c)
    task automatic bc_model(input logic [7:0] r, input logic [7:0] c, input bit clr);
        int p;
        p = int'(r) * int'(c);
        if (clr) begin
            b_sat = p; c_wrap = p; b_ovf = 1'b0; c_ovf = 1'b0;
        end else begin
            if (b_sat + p > 65535) begin b_sat = 65535; b_ovf = 1'b1; end
            else b_sat += p;
            if (c_wrap + p > 65535) begin c_wrap = c_wrap + p - 65536; c_ovf = 1'b1; end
            else c_wrap += p;
        end
    endtask

    task automatic a_cycle(input bit ld, input bit clr, input bit dr, input logic [31:0] row, input logic [31:0] col);
        ia.load_in = ld; ia.acc_clr = clr; ia.drain_in = dr; ia.row_in = row; ia.col_in = col;
        if (ld) a_model(row, col, clr);
        @(posedge clk); #1;
        ia.load_in = 1'b0; ia.acc_clr = 1'b0; ia.drain_in = 1'b0;
    endtask

    task automatic b_cycle(input bit ld, input bit clr, input bit dr, input logic [7:0] row, input logic [7:0] col);
        ib.load_in = ld; ib.acc_clr = clr; ib.drain_in = dr; ib.row_in = row; ib.col_in = col;
        if (ld) bc_model(row, col, clr);
        @(posedge clk); #1;
        ib.load_in = 1'b0; ib.acc_clr = 1'b0; ib.drain_in = 1'b0;
    endtask

    task automatic a_wait(input string tag, output int lat);
        bit          seen;
        logic [31:0] ea;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ia.result_vld === 1'b1) begin seen = 1'b1; lat = i; end
        end
        ea = a_acc[31:0];
        chk({tag, "_vld"}, 64'(seen), 64'(1));
        chk({tag, "_res"}, 64'(ia.pe_result), 64'(ea));
        chk({tag, "_ovf"}, 64'(ia.overflow), 64'(a_ovf));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(ia.result_vld), 64'(0));
        chk({tag, "_hold"}, 64'(ia.pe_result), 64'(ea));
        chk({tag, "_done"}, 64'(ia.done_pe), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic bc_wait(input string tag);
        bit          seen;
        logic [15:0] eb, ec;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ib.result_vld === 1'b1 && ic.result_vld === 1'b1) seen = 1'b1;
        end
        eb = 16'(b_sat);
        ec = 16'(c_wrap);
        chk({tag, "_vld"}, 64'(seen), 64'(1));
        chk({tag, "_sat_res"}, 64'(ib.pe_result), 64'(eb));
        chk({tag, "_sat_ovf"}, 64'(ib.overflow), 64'(b_ovf));
        chk({tag, "_wrap_res"}, 64'(ic.pe_result), 64'(ec));
        chk({tag, "_wrap_ovf"}, 64'(ic.overflow), 64'(c_ovf));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'({ib.result_vld, ic.result_vld}), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        int          cnt;
        bit          dsame;
        logic [31:0] r, c;

        ia.load_in = 1'b0; ia.acc_clr = 1'b0; ia.drain_in = 1'b0; ia.row_in = '0; ia.col_in = '0;
        ib.load_in = 1'b0; ib.acc_clr = 1'b0; ib.drain_in = 1'b0; ib.row_in = '0; ib.col_in = '0;
        dsame = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(ia.ready_out), 64'(1));
        chk("rst_done", 64'(ia.done_pe), 64'(1));
        chk("rst_load_out", 64'(ia.load_out), 64'(0));
        chk("rst_result_vld", 64'(ia.result_vld), 64'(0));
        chk("rst_overflow", 64'(ia.overflow), 64'(0));
        chk("rst_pe_result", 64'(ia.pe_result), 64'(0));
        chk("rst_row_out", 64'(ia.row_out), 64'(0));
        @(posedge clk); #1;

        // 3*-4 + 5*6 on lane 0, then a drain from RUN
        a_cycle(1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_00FC);
        chk("fwd_load_out", 64'(ia.load_out), 64'(1));
        chk("fwd_row_out", 64'(ia.row_out), 64'(32'h3));
        chk("fwd_col_out", 64'(ia.col_out), 64'(32'hFC));
        a_cycle(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0006);
        a_cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        a_wait("dot18", lat);
        chk("dot18_const", 64'(ia.pe_result), 64'(18));

        // Drain from IDLE with empty pipeline presents the retained accumulator
        a_cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        a_wait("idle_drain", lat);
        chk("idle_drain_latency", 64'(lat), 64'(1));

        // Four lanes with drain in the accepting cycle
        a_cycle(1'b1, 1'b1, 1'b1, 32'h0403_0201, 32'h0807_0605);
        chk("lanes_row_out", 64'(ia.row_out), 64'(32'h0403_0201));
        chk("lanes_col_out", 64'(ia.col_out), 64'(32'h0807_0605));
        a_wait("lanes70", lat);
        chk("lanes70_const", 64'(ia.pe_result), 64'(70));

        // Random signed dot products, some with a dropped load during FLUSH
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                r = $urandom;
                c = $urandom;
                dsame = (j == n - 1) && ($urandom_range(0, 1) == 1);
                a_cycle(1'b1, j == 0, dsame, r, c);
                if (!dsame && $urandom_range(0, 3) == 0) a_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (!dsame) begin
                a_cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
            end else begin
                ia.load_in = 1'b1; ia.row_in = $urandom; ia.col_in = $urandom;
                @(negedge clk);
                chk("a_flush_ready", 64'(ia.ready_out), 64'(0));
                @(posedge clk); #1;
                ia.load_in = 1'b0;
                chk("a_flush_load_out", 64'(ia.load_out), 64'(0));
            end
            a_wait("rand_a", lat);
        end

        // 255*255 twice: saturate vs wrap, both overflow
        b_cycle(1'b1, 1'b1, 1'b0, 8'd255, 8'd255);
        b_cycle(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
        b_cycle(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        bc_wait("u255");
        chk("u255_sat_const", 64'(ib.pe_result), 64'(16'hFFFF));
        chk("u255_wrap_const", 64'(ic.pe_result), 64'(64514));

        // A clearing load resets the sticky overflow
        b_cycle(1'b1, 1'b1, 1'b1, 8'd1, 8'd1);
        bc_wait("clr_ovf");
        chk("clr_ovf_const", 64'(ib.overflow), 64'(0));

        // Three 2*2 loads, drain with the last, a load during FLUSH is dropped
        b_cycle(1'b1, 1'b1, 1'b0, 8'd2, 8'd2);
        b_cycle(1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
        b_cycle(1'b1, 1'b0, 1'b1, 8'd2, 8'd2);
        ib.load_in = 1'b1; ib.row_in = 8'd9; ib.col_in = 8'd9;
        @(negedge clk);
        chk("b_flush_ready", 64'(ib.ready_out), 64'(0));
        @(posedge clk); #1;
        ib.load_in = 1'b0;
        chk("b_flush_load_out", 64'(ib.load_out), 64'(0));
        chk("b_flush_row_hold", 64'(ib.row_out), 64'(2));
        bc_wait("drain_same");
        chk("drain_same_const", 64'(ib.pe_result), 64'(12));

        // Random unsigned accumulations exercising saturation and wrap
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                b_cycle(1'b1, j == 0, 1'b0, 8'($urandom), 8'($urandom));
            end
            b_cycle(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
            bc_wait("rand_bc");
        end

        // Reset one cycle after a load: everything returns to reset values, no result
        a_cycle(1'b1, 1'b1, 1'b0, $urandom, $urandom);
        rst = 1'b1;
        ia.drain_in = 1'b1;
        @(posedge clk); #1;
        ia.drain_in = 1'b0;
        chk("rstmid_load_out", 64'(ia.load_out), 64'(0));
        chk("rstmid_row_out", 64'(ia.row_out), 64'(0));
        chk("rstmid_col_out", 64'(ia.col_out), 64'(0));
        chk("rstmid_ready", 64'(ia.ready_out), 64'(1));
        chk("rstmid_done", 64'(ia.done_pe), 64'(1));
        chk("rstmid_result_vld", 64'(ia.result_vld), 64'(0));
        chk("rstmid_overflow", 64'(ia.overflow), 64'(0));
        chk("rstmid_pe_result", 64'(ia.pe_result), 64'(0));
        chk("rstmid_b_pe_result", 64'(ib.pe_result), 64'(0));
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ia.result_vld === 1'b1) cnt++;
        end
        chk("rstmid_no_result", 64'(cnt), 64'(0));
        chk("rstmid_done_after", 64'(ia.done_pe), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
